// File: rtl/alu_core.sv
// 16-bit ALU stage: single-cycle arithmetic/logic ops, plus sequential shift-add multiply
// and restoring divide, with a busy/done handshake back to the control unit.
module alu_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] A_BUS_out,
  input  logic [WIDTH-1:0] B_BUS_out,
  input  logic [3:0]       ALU_op,
  input  logic             ALU_start,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Z_flag,
  output logic             C_flag,
  output logic             ALU_busy,
  output logic             ALU_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_PASSA = 4'd3, OP_PASSB = 4'd4,
    OP_INC = 4'd5, OP_DEC = 4'd6, OP_AND = 4'd7, OP_OR = 4'd8, OP_XOR = 4'd9,
    OP_MUL = 4'd10, OP_DIV = 4'd11
  } op_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               z_q, z_d, c_q, c_d, done_q, done_d;

  logic [WIDTH:0]     sum_w, shf_w, trl_w;
  logic [WIDTH-1:0]   res;
  logic               cy, wr, qbit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    out_d   = out_q;
    z_d     = z_q;
    c_d     = c_q;
    done_d  = 1'b0;
    sum_w   = '0;
    shf_w   = '0;
    trl_w   = '0;
    res     = '0;
    cy      = 1'b0;
    wr      = 1'b0;
    qbit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ALU_start) begin
          done_d = 1'b1;
          case (ALU_op)
            OP_ADD: begin
              sum_w = {1'b0, A_BUS_out} + {1'b0, B_BUS_out};
              res = sum_w[WIDTH-1:0]; cy = sum_w[WIDTH]; wr = 1'b1;
            end
            OP_SUB: begin
              sum_w = {1'b0, A_BUS_out} - {1'b0, B_BUS_out};
              res = sum_w[WIDTH-1:0]; cy = sum_w[WIDTH]; wr = 1'b1;
            end
            OP_PASSA: begin res = A_BUS_out; wr = 1'b1; end
            OP_PASSB: begin res = B_BUS_out; wr = 1'b1; end
            OP_INC: begin
              sum_w = {1'b0, A_BUS_out} + 1'b1;
              res = sum_w[WIDTH-1:0]; cy = sum_w[WIDTH]; wr = 1'b1;
            end
            OP_DEC: begin
              sum_w = {1'b0, A_BUS_out} - 1'b1;
              res = sum_w[WIDTH-1:0]; cy = sum_w[WIDTH]; wr = 1'b1;
            end
            OP_AND: begin res = A_BUS_out & B_BUS_out; wr = 1'b1; end
            OP_OR:  begin res = A_BUS_out | B_BUS_out; wr = 1'b1; end
            OP_XOR: begin res = A_BUS_out ^ B_BUS_out; wr = 1'b1; end
            OP_MUL: begin
              done_d  = 1'b0;
              state_d = S_MUL;
              cnt_d   = '0;
              acc_d   = {{WIDTH{1'b0}}, B_BUS_out};
              opb_d   = A_BUS_out;
            end
            OP_DIV: begin
              if (B_BUS_out == '0) begin
                res = '1; cy = 1'b1; wr = 1'b1;
              end else begin
                done_d  = 1'b0;
                state_d = S_DIV;
                cnt_d   = '0;
                acc_d   = {{WIDTH{1'b0}}, A_BUS_out};
                opb_d   = B_BUS_out;
                rem_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end

      // Multiplier sits in the low half and shifts out as the partial product shifts in.
      S_MUL: begin
        sum_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_d = {sum_w, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          res     = acc_d[WIDTH-1:0];
          cy      = |acc_d[2*WIDTH-1:WIDTH];
          wr      = 1'b1;
        end
      end

      // Dividend bits shift out of the low half of acc while quotient bits shift in.
      S_DIV: begin
        shf_w = {rem_q, acc_q[WIDTH-1]};
        trl_w = shf_w - {1'b0, opb_q};
        qbit  = ~trl_w[WIDTH];
        rem_d = qbit ? trl_w[WIDTH-1:0] : shf_w[WIDTH-1:0];
        acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          res     = acc_d[WIDTH-1:0];
          wr      = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      out_d = res;
      c_d   = cy;
      z_d   = (res == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      out_q   <= '0;
      z_q     <= 1'b1;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      z_q     <= z_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign ALU_out  = out_q;
  assign Z_flag   = z_q;
  assign C_flag   = c_q;
  assign ALU_done = done_q;
  assign ALU_busy = (state_q != S_IDLE);

endmodule

// File: doc/alu_core.md
# alu_core

Arithmetic/logic stage directly downstream of the B-bus multiplexer and its A-bus counterpart. Operands are captured from the registered A and B buses on a start strobe from the control unit. Single-cycle ops complete in one clock. Multiply and divide run as 16-iteration sequential loops. The registered 16-bit result, zero/carry flags and a busy/done handshake are returned to the control unit and the C-bus write-back path.

## Interface
Parameters:
- WIDTH, 16, datapath width; ops and test values are specified for 16.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset_n  in  1  synchronous, active-low reset, sampled on rising edge of Clock.
- A_BUS_out  in  WIDTH  operand A, from the A-bus mux register.
- B_BUS_out  in  WIDTH  operand B, from the B-bus mux register.
- ALU_op  in  4  operation code, sampled with ALU_start.
- ALU_start  in  1  one-cycle request strobe from control.
- ALU_out  out  WIDTH  registered result.
- Z_flag  out  1  result == 0, updated with ALU_out.
- C_flag  out  1  carry/borrow/overflow/div-by-zero, updated with ALU_out.
- ALU_busy  out  1  high while a multi-cycle op is in progress.
- ALU_done  out  1  one-cycle pulse when the result is valid.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD A+B
  - 2 SUB A−B
  - 3 PASSA
  - 4 PASSB
  - 5 INC A
  - 6 DEC A
  - 7 AND
  - 8 OR
  - 9 XOR
  - 10 MUL (low 16 bits of A×B, unsigned)
  - 11 DIV (A/B quotient, unsigned)
  - 12–15 reserved.
- States: IDLE, MUL, DIV.
  - IDLE, ALU_start=1, op 10 → MUL.
  - IDLE, ALU_start=1, op 11 with B≠0 → DIV.
  - MUL/DIV → IDLE after 16 iterations.
- Operands are latched into internal registers at the start edge. Bus changes afterwards have no effect.
- Single-cycle ops (1–9): ALU_out, Z_flag and C_flag are written at the start edge.
- C_flag rules:
  - ADD/INC: carry out of bit 15.
  - SUB/DEC: borrow (operand A < subtrahend).
  - AND/OR/XOR/PASS: 0.
  - MUL: 1 if any of the upper 16 product bits are nonzero.
  - DIV: 0 normally; 1 on divide-by-zero.
- MUL: shift-add, one multiplier bit per cycle. 32-bit accumulator internally, count 0..15.
- DIV: restoring division, one quotient bit per cycle. The remainder is kept internally and is not output.
- Divide-by-zero (op 11, B=0):
  - Single-cycle; no DIV state entered.
  - ALU_out=16'hFFFF, C_flag=1, Z_flag=0.
- NOP and reserved opcodes: ALU_done pulses; ALU_out and flags are unchanged.
- ALU_start while ALU_busy=1 is ignored; there is no queuing.
- The ALU_start edge that ends a multi-cycle op (the done edge) is also ignored. A new request is accepted only when ALU_busy=0.

## Timing
- Reset (Reset_n=0 at an edge):
  - ALU_out=0, Z_flag=1, C_flag=0, ALU_busy=0, ALU_done=0, state IDLE.
  - Any MUL/DIV in flight is aborted; no done pulse is produced.
- Single-cycle op, start sampled at edge N:
  - Result and flags are valid after edge N.
  - ALU_done=1 for the cycle between N and N+1.
  - ALU_busy stays 0.
- MUL/DIV, start sampled at edge N:
  - ALU_busy=1 after edge N.
  - One iteration is performed at each of edges N+1 … N+16.
  - At edge N+16: ALU_out and flags are written, ALU_done=1, ALU_busy=0.
  - Latency is 16 cycles. The next start is accepted at edge N+17.
- ALU_done is never high for two consecutive cycles unless back-to-back single-cycle ops are issued.
- ALU_out holds its value between operations.

## Test plan
- Reset: assert Reset_n=0 for 2 cycles → ALU_out=0, Z=1, C=0, busy=0, done=0.
- ADD 16'hFFFF + 16'h0001 → ALU_out=0, Z=1, C=1, done pulse one cycle after start. Then SUB 16'h0003 − 16'h0005 → 16'hFFFE, C=1, Z=0.
- MUL 16'h0123 × 16'h0010 → busy for 16 cycles, then ALU_out=16'h1230, C=0. MUL 16'h1000 × 16'h0010 → ALU_out=0, Z=1, C=1. A start pulse at cycle 5 of the op is ignored.
- DIV 16'd1000 / 16'd7 → ALU_out=16'd142 at start+16, C=0. DIV with B=0 → 16'hFFFF, C=1 after one cycle, busy never asserted.
- Reset_n=0 at cycle 8 of a DIV → no done pulse; outputs take reset values. A following ADD 2+3 → 5 with normal timing.
